// File: rtl/l1_veri_yolu_hakem_if.sv
// ---------------------------------------------------------------------------
// l1_veri_yolu_hakem_if : port B, port V and bus-side signals of the L1 arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface l1_veri_yolu_hakem_if #(
  parameter int ADRES_BIT = 32,
  parameter int BLOK_BIT  = 128
);
  logic [ADRES_BIT-1:0] b_istek_adres_i;
  logic                 b_istek_gecerli_i;
  logic                 b_istek_yaz_i;
  logic [BLOK_BIT-1:0]  b_istek_veri_i;
  logic                 b_istek_hazir_o;
  logic [BLOK_BIT-1:0]  b_veri_o;
  logic                 b_veri_gecerli_o;
  logic                 b_veri_hazir_i;

  logic [ADRES_BIT-1:0] v_istek_adres_i;
  logic                 v_istek_gecerli_i;
  logic                 v_istek_yaz_i;
  logic [BLOK_BIT-1:0]  v_istek_veri_i;
  logic                 v_istek_hazir_o;
  logic [BLOK_BIT-1:0]  v_veri_o;
  logic                 v_veri_gecerli_o;
  logic                 v_veri_hazir_i;

  logic [ADRES_BIT-1:0] vy_istek_adres_o;
  logic                 vy_istek_gecerli_o;
  logic                 vy_istek_yaz_o;
  logic [BLOK_BIT-1:0]  vy_istek_veri_o;
  logic                 vy_istek_hazir_i;
  logic [BLOK_BIT-1:0]  vy_veri_i;
  logic                 vy_veri_gecerli_i;
  logic                 vy_veri_hazir_o;

  modport slave (
    input  b_istek_adres_i, b_istek_gecerli_i, b_istek_yaz_i, b_istek_veri_i, b_veri_hazir_i,
    output b_istek_hazir_o, b_veri_o, b_veri_gecerli_o,
    input  v_istek_adres_i, v_istek_gecerli_i, v_istek_yaz_i, v_istek_veri_i, v_veri_hazir_i,
    output v_istek_hazir_o, v_veri_o, v_veri_gecerli_o,
    output vy_istek_adres_o, vy_istek_gecerli_o, vy_istek_yaz_o, vy_istek_veri_o, vy_veri_hazir_o,
    input  vy_istek_hazir_i, vy_veri_i, vy_veri_gecerli_i
  );

  modport master (
    output b_istek_adres_i, b_istek_gecerli_i, b_istek_yaz_i, b_istek_veri_i, b_veri_hazir_i,
    input  b_istek_hazir_o, b_veri_o, b_veri_gecerli_o,
    output v_istek_adres_i, v_istek_gecerli_i, v_istek_yaz_i, v_istek_veri_i, v_veri_hazir_i,
    input  v_istek_hazir_o, v_veri_o, v_veri_gecerli_o,
    input  vy_istek_adres_o, vy_istek_gecerli_o, vy_istek_yaz_o, vy_istek_veri_o, vy_veri_hazir_o,
    output vy_istek_hazir_i, vy_veri_i, vy_veri_gecerli_i
  );
endinterface

`default_nettype wire

// File: rtl/l1_veri_yolu_hakem.sv
// ---------------------------------------------------------------------------
// l1_veri_yolu_hakem : one-outstanding arbiter of L1 I-cache (B) and D-cache (V)
// onto the bus controller; HAKEM_SABIT_ONCELIK_EN selects fixed V priority.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l1_veri_yolu_hakem #(
  parameter int ADRES_BIT = 32,
  parameter int BLOK_BIT  = 128
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  l1_veri_yolu_hakem_if.slave   bus
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_t;

  durum_t               durum_q, durum_d;
  logic                 secim_q, secim_d;
  logic                 yaz_q, yaz_d;
  logic [ADRES_BIT-1:0] adres_q, adres_d;
  logic [BLOK_BIT-1:0]  veri_q, veri_d;
  logic                 ikili_kazanan;
  logic                 kazanan;
  logic                 yanit_hazir;

`ifdef HAKEM_SABIT_ONCELIK_EN
  assign ikili_kazanan = 1'b1;
`else
  logic oncelik_q;

  // Priority flips to the other port whenever a transaction finishes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      oncelik_q <= 1'b0;
    else if (durum_q != BOSTA && durum_d == BOSTA)
      oncelik_q <= ~secim_q;
  end

  assign ikili_kazanan = oncelik_q;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q <= BOSTA;
      secim_q <= 1'b0;
      yaz_q   <= 1'b0;
      adres_q <= '0;
      veri_q  <= '0;
    end else begin
      durum_q <= durum_d;
      secim_q <= secim_d;
      yaz_q   <= yaz_d;
      adres_q <= adres_d;
      veri_q  <= veri_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    secim_d = secim_q;
    yaz_d   = yaz_q;
    adres_d = adres_q;
    veri_d  = veri_q;
    kazanan = 1'b0;
    yanit_hazir = 1'b0;

    bus.b_istek_hazir_o    = 1'b0;
    bus.v_istek_hazir_o    = 1'b0;
    bus.b_veri_o           = bus.vy_veri_i;
    bus.v_veri_o           = bus.vy_veri_i;
    bus.b_veri_gecerli_o   = 1'b0;
    bus.v_veri_gecerli_o   = 1'b0;
    bus.vy_istek_gecerli_o = 1'b0;
    bus.vy_istek_adres_o   = adres_q;
    bus.vy_istek_yaz_o     = yaz_q;
    bus.vy_istek_veri_o    = veri_q;
    bus.vy_veri_hazir_o    = 1'b0;

    case (durum_q)
      BOSTA: begin
        // Gated by rstn_i so no ready leaks out while reset is held.
        if (rstn_i && (bus.b_istek_gecerli_i || bus.v_istek_gecerli_i)) begin
          kazanan = bus.v_istek_gecerli_i && (!bus.b_istek_gecerli_i || ikili_kazanan);
          bus.b_istek_hazir_o = ~kazanan;
          bus.v_istek_hazir_o = kazanan;
          secim_d = kazanan;
          adres_d = kazanan ? bus.v_istek_adres_i : bus.b_istek_adres_i;
          yaz_d   = kazanan ? bus.v_istek_yaz_i   : bus.b_istek_yaz_i;
          veri_d  = kazanan ? bus.v_istek_veri_i  : bus.b_istek_veri_i;
          durum_d = ISTEK;
        end
      end
      ISTEK: begin
        bus.vy_istek_gecerli_o = 1'b1;
        if (bus.vy_istek_hazir_i)
          durum_d = yaz_q ? BOSTA : YANIT;
      end
      YANIT: begin
        if (secim_q) begin
          bus.v_veri_gecerli_o = bus.vy_veri_gecerli_i;
          yanit_hazir          = bus.v_veri_hazir_i;
        end else begin
          bus.b_veri_gecerli_o = bus.vy_veri_gecerli_i;
          yanit_hazir          = bus.b_veri_hazir_i;
        end
        bus.vy_veri_hazir_o = yanit_hazir;
        if (bus.vy_veri_gecerli_i && yanit_hazir)
          durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_l1_veri_yolu_hakem.sv
// ---------------------------------------------------------------------------
// tb_l1_veri_yolu_hakem : table vectors, corner sequences and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_l1_veri_yolu_hakem;
  localparam int AB = 32;
  localparam int BB = 128;
`ifdef HAKEM_SABIT_ONCELIK_EN
  localparam bit SABIT = 1'b1;
`else
  localparam bit SABIT = 1'b0;
`endif

  typedef struct {
    logic          b_g, v_g, b_yaz, v_yaz;
    logic [AB-1:0] b_adres, v_adres;
    logic [BB-1:0] b_veri, v_veri, yanit;
    int            ib, vb;
    logic          exp_v;
  } vektor_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic son_v = 1'b1;   // last served port: 1 = V, so B is preferred first

  always #5 clk = ~clk;

  l1_veri_yolu_hakem_if #(.ADRES_BIT(AB), .BLOK_BIT(BB)) bus ();

  l1_veri_yolu_hakem #(.ADRES_BIT(AB), .BLOK_BIT(BB)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  task automatic chk(input string ad, input logic [BB-1:0] gercek, input logic [BB-1:0] beklenen);
    n_cmp++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic logic model_kazanan(input logic b, input logic v);
    if (b && !v) return 1'b0;
    if (v && !b) return 1'b1;
    if (SABIT)   return 1'b1;
    return (son_v == 1'b1) ? 1'b0 : 1'b1;
  endfunction

  // Entered and left at posedge+2; runs one full transaction and checks it.
  task automatic islem(input vektor_t t, input logic exp_v);
    logic          k_yaz;
    logic [AB-1:0] k_adr;
    logic [BB-1:0] k_veri;
    bus.b_istek_gecerli_i = t.b_g;  bus.b_istek_yaz_i = t.b_yaz;
    bus.b_istek_adres_i   = t.b_adres; bus.b_istek_veri_i = t.b_veri;
    bus.v_istek_gecerli_i = t.v_g;  bus.v_istek_yaz_i = t.v_yaz;
    bus.v_istek_adres_i   = t.v_adres; bus.v_istek_veri_i = t.v_veri;
    k_yaz  = exp_v ? t.v_yaz   : t.b_yaz;
    k_adr  = exp_v ? t.v_adres : t.b_adres;
    k_veri = exp_v ? t.v_veri  : t.b_veri;
    #1;
    chk("b_istek_hazir", bus.b_istek_hazir_o, !exp_v);
    chk("v_istek_hazir", bus.v_istek_hazir_o, exp_v);
    chk("vy_gecerli_bosta", bus.vy_istek_gecerli_o, 0);
    @(posedge clk); #1;
    if (exp_v) begin
      bus.v_istek_gecerli_i = 1'b0; bus.v_istek_adres_i = $urandom;
    end else begin
      bus.b_istek_gecerli_i = 1'b0; bus.b_istek_adres_i = $urandom;
    end
    #1;
    for (int i = 0; i <= t.ib; i++) begin
      chk("vy_istek_gecerli", bus.vy_istek_gecerli_o, 1);
      chk("vy_istek_adres", bus.vy_istek_adres_o, k_adr);
      chk("vy_istek_yaz", bus.vy_istek_yaz_o, k_yaz);
      if (k_yaz) chk("vy_istek_veri", bus.vy_istek_veri_o, k_veri);
      chk("istek_hazir_mesgul", {bus.b_istek_hazir_o, bus.v_istek_hazir_o}, 0);
      if (i == t.ib) bus.vy_istek_hazir_i = 1'b1;
      @(posedge clk); #1;
      bus.vy_istek_hazir_i = 1'b0;
      #1;
    end
    if (k_yaz) begin
      chk("yaz_sonu_gecerli", bus.vy_istek_gecerli_o, 0);
      chk("yaz_veri_gecerli", {bus.b_veri_gecerli_o, bus.v_veri_gecerli_o}, 0);
    end else begin
      logic [BB-1:0] rd;
      rd = t.yanit;
      chk("yanit_istek_gecerli", bus.vy_istek_gecerli_o, 0);
      bus.vy_veri_i = rd; bus.vy_veri_gecerli_i = 1'b1;
      bus.b_veri_hazir_i = exp_v;   // loser ready high to expose a wrong mux
      bus.v_veri_hazir_i = !exp_v;
      for (int i = 0; i <= t.vb; i++) begin
        if (i == t.vb) begin
          if (exp_v) bus.v_veri_hazir_i = 1'b1; else bus.b_veri_hazir_i = 1'b1;
        end
        #1;
        chk("b_veri_gecerli", bus.b_veri_gecerli_o, !exp_v);
        chk("v_veri_gecerli", bus.v_veri_gecerli_o, exp_v);
        chk("kazanan_veri", exp_v ? bus.v_veri_o : bus.b_veri_o, rd);
        chk("vy_veri_hazir", bus.vy_veri_hazir_o, i == t.vb);
        chk("istek_hazir_yanit", {bus.b_istek_hazir_o, bus.v_istek_hazir_o}, 0);
        @(posedge clk); #1;
      end
      bus.vy_veri_gecerli_i = 1'b0; bus.b_veri_hazir_i = 1'b0; bus.v_veri_hazir_i = 1'b0;
      #1;
      chk("yanit_sonu", {bus.b_veri_gecerli_o, bus.v_veri_gecerli_o, bus.vy_veri_hazir_o}, 0);
    end
    son_v = exp_v;
  endtask

  vektor_t tablo[7];
  vektor_t r;

  initial begin
    bus.b_istek_gecerli_i = 1'b1; bus.b_istek_yaz_i = 1'b0;
    bus.b_istek_adres_i = '0; bus.b_istek_veri_i = '0; bus.b_veri_hazir_i = 1'b0;
    bus.v_istek_gecerli_i = 1'b0; bus.v_istek_yaz_i = 1'b0;
    bus.v_istek_adres_i = '0; bus.v_istek_veri_i = '0; bus.v_veri_hazir_i = 1'b0;
    bus.vy_istek_hazir_i = 1'b0; bus.vy_veri_i = '0; bus.vy_veri_gecerli_i = 1'b0;

    tablo[0] = '{1, 1, 0, 0, 32'h0000_0100, 32'h0000_0140, '0, '0,
                 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000001, 0, 0, SABIT ? 1'b1 : 1'b0};
    tablo[1] = '{1, 1, 0, 0, 32'h0000_0180, 32'h0000_01C0, '0, '0,
                 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, 0, 1'b1};
    tablo[2] = '{1, 1, 0, 0, 32'h0000_0200, 32'h0000_0240, '0, '0,
                 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 0, 1, SABIT ? 1'b1 : 1'b0};
    tablo[3] = '{1, 1, 0, 0, 32'h0000_0280, 32'h0000_02C0, '0, '0,
                 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 2, 0, 1'b1};
    tablo[4] = '{0, 1, 0, 1, 32'h0000_0000, 32'h0000_2000, '0, {16{8'hA5}},
                 '0, 5, 0, 1'b1};
    tablo[5] = '{1, 0, 0, 0, 32'h0000_3000, 32'h0000_0000, '0, '0,
                 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 0, 3, 1'b0};
    tablo[6] = '{1, 0, 0, 0, 32'h0000_0100, 32'h0000_0000, '0, '0,
                 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000001, 0, 0, 1'b0};

    // Reset state, with a B request already pending.
    #3;
    chk("rst_b_istek_hazir", bus.b_istek_hazir_o, 0);
    chk("rst_vy_gecerli", bus.vy_istek_gecerli_o, 0);
    chk("rst_vy_adres", bus.vy_istek_adres_o, 0);
    chk("rst_vy_yaz_veri", {bus.vy_istek_yaz_o, bus.vy_istek_veri_o}, 0);
    chk("rst_veri_gecerli", {bus.b_veri_gecerli_o, bus.v_veri_gecerli_o, bus.vy_veri_hazir_o}, 0);
    @(posedge clk); #2;
    rstn = 1'b1;

    foreach (tablo[k]) islem(tablo[k], tablo[k].exp_v);

    // Spurious bus response while idle.
    bus.b_istek_gecerli_i = 1'b0; bus.v_istek_gecerli_i = 1'b0;
    bus.vy_veri_gecerli_i = 1'b1; bus.b_veri_hazir_i = 1'b1; bus.v_veri_hazir_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("sahte_veri_gecerli", {bus.b_veri_gecerli_o, bus.v_veri_gecerli_o}, 0);
      chk("sahte_vy_hazir", bus.vy_veri_hazir_o, 0);
      @(posedge clk); #1;
    end
    bus.vy_veri_gecerli_i = 1'b0; bus.b_veri_hazir_i = 1'b0; bus.v_veri_hazir_i = 1'b0;
    #1;
    islem(tablo[6], 1'b0);

    // Reset while waiting for the response.
    bus.b_istek_adres_i = 32'h0000_0300; bus.b_istek_yaz_i = 1'b0; bus.b_istek_gecerli_i = 1'b1;
    #1;
    @(posedge clk); #1;
    bus.b_istek_gecerli_i = 1'b0; bus.vy_istek_hazir_i = 1'b1;
    @(posedge clk); #1;
    bus.vy_istek_hazir_i = 1'b0; bus.vy_veri_gecerli_i = 1'b1; bus.vy_veri_i = {4{32'h5A5A_0001}};
    #1;
    chk("rstoncesi_b_veri_gecerli", bus.b_veri_gecerli_o, 1);
    bus.b_istek_gecerli_i = 1'b1;
    rstn = 1'b0;
    #1;
    chk("rst_yanit_veri_gecerli", {bus.b_veri_gecerli_o, bus.v_veri_gecerli_o}, 0);
    chk("rst_yanit_vy", {bus.vy_istek_gecerli_o, bus.vy_veri_hazir_o}, 0);
    chk("rst_yanit_istek_hazir", {bus.b_istek_hazir_o, bus.v_istek_hazir_o}, 0);
    bus.vy_veri_gecerli_i = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    son_v = 1'b1;
    islem(tablo[5], 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      r.b_g = 1'($urandom); r.v_g = 1'($urandom);
      if (!r.b_g && !r.v_g) r.b_g = 1'b1;
      r.b_yaz = 1'($urandom); r.v_yaz = 1'($urandom);
      r.b_adres = $urandom; r.v_adres = $urandom;
      r.b_veri = {$urandom, $urandom, $urandom, $urandom};
      r.v_veri = {$urandom, $urandom, $urandom, $urandom};
      r.yanit  = {$urandom, $urandom, $urandom, $urandom};
      r.ib = int'($urandom_range(0, 3)); r.vb = int'($urandom_range(0, 3));
      r.exp_v = model_kazanan(r.b_g, r.v_g);
      islem(r, r.exp_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
